// File: rtl/expansion_timer.sv
// expansion_timer: NUM_CH down-counting timers behind the 8-bit expansion bus.
// Each channel has a RELOAD value, a live COUNT, CTRL (EN/PERIODIC/IRQEN) and a
// sticky EXP flag. All channels share one prescaler; a shared snapshot keeps
// multi-byte COUNT reads consistent while the counter is running.
module expansion_timer #(
    parameter int         NUM_CH    = 4,
    parameter int         WIDTH     = 16,
    parameter logic [7:0] BASE_ADDR = 8'h40
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    output logic       o_busNOE,
    input  logic       i_ioSelect,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    output logic       o_irq
);

    localparam int         NB        = WIDTH / 8;
    localparam logic [8:0] WIN_LO    = {1'b0, BASE_ADDR};
    localparam logic [8:0] WIN_HI    = 9'(int'(BASE_ADDR) + NUM_CH * 16 + 2);
    localparam logic [7:0] OFF_IRQ   = 8'(NUM_CH * 16);
    localparam logic [7:0] OFF_PRESC = 8'(NUM_CH * 16 + 1);

    logic [WIDTH-1:0]  reload_q [NUM_CH];
    logic [WIDTH-1:0]  reload_d [NUM_CH];
    logic [WIDTH-1:0]  count_q  [NUM_CH];
    logic [WIDTH-1:0]  count_d  [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, per_q, per_d, ien_q, ien_d, exp_q, exp_d;
    logic [7:0]        presc_q, presc_d, pcnt_q, pcnt_d;
    logic [WIDTH-1:0]  snap_q, snap_d;
    logic              nwe_q, noe_q, irq_q;

    logic       hit, ch_ok, wr, rd_rise, tick;
    logic [7:0] off, rd_byte;
    logic [2:0] ch_idx;
    logic [3:0] rg;
    logic [31:0] rld_w, snap_w;

    assign hit     = i_ioSelect && ({1'b0, i_ioAddress} >= WIN_LO) && ({1'b0, i_ioAddress} < WIN_HI);
    assign off     = i_ioAddress - BASE_ADDR;
    assign ch_idx  = off[6:4];
    assign rg      = off[3:0];
    assign ch_ok   = off < OFF_IRQ;
    assign wr      = hit && !i_ioNWE && nwe_q;
    assign rd_rise = hit && !i_ioNOE && noe_q;
    assign tick    = (pcnt_q == presc_q);
    assign snap_w  = 32'(snap_q);

    // Next-state for prescaler, snapshot and all channel registers.
    // Order inside a channel matters: W1C first so a same-cycle expiry wins,
    // then the tick, then a CTRL write so the written EN beats the one-shot clear.
    always_comb begin
        presc_d  = presc_q;
        pcnt_d   = tick ? 8'd0 : pcnt_q + 8'd1;
        snap_d   = snap_q;
        reload_d = reload_q;
        count_d  = count_q;
        en_d     = en_q;
        per_d    = per_q;
        ien_d    = ien_q;
        exp_d    = exp_q;

        if (wr && off == OFF_PRESC) begin
            presc_d = i_bus;
            pcnt_d  = 8'd0;
        end

        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_rise && ch_ok && rg == 4'h4 && ch_idx == 3'(c)) begin
                snap_d = count_q[c];
            end

            if (wr && ch_ok && ch_idx == 3'(c)) begin
                if (rg == 4'h9 && i_bus[0]) begin
                    exp_d[c] = 1'b0;
                end
                for (int b = 0; b < NB; b++) begin
                    if (rg == 4'(b)) begin
                        reload_d[c][8*b +: 8] = i_bus;
                    end
                end
            end

            if (tick && en_q[c]) begin
                if (count_q[c] != '0) begin
                    count_d[c] = count_q[c] - WIDTH'(1);
                end else begin
                    exp_d[c] = 1'b1;
                    if (per_q[c]) begin
                        count_d[c] = reload_q[c];
                    end else begin
                        en_d[c] = 1'b0;
                    end
                end
            end

            if (wr && ch_ok && ch_idx == 3'(c) && rg == 4'h8) begin
                en_d[c]  = i_bus[0];
                per_d[c] = i_bus[1];
                ien_d[c] = i_bus[2];
                if (i_bus[0] && !en_q[c]) begin
                    count_d[c] = reload_q[c];
                end
            end
        end
    end

    // Register update; strobe history resets to idle-high so no commit fires on reset release.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                reload_q[c] <= '0;
                count_q[c]  <= '0;
            end
            en_q    <= '0;
            per_q   <= '0;
            ien_q   <= '0;
            exp_q   <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            snap_q  <= '0;
            nwe_q   <= 1'b1;
            noe_q   <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
            en_q     <= en_d;
            per_q    <= per_d;
            ien_q    <= ien_d;
            exp_q    <= exp_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            snap_q   <= snap_d;
            nwe_q    <= i_ioNWE;
            noe_q    <= i_ioNOE;
            irq_q    <= |(exp_q & ien_q);
        end
    end

    // Read data mux; bytes beyond WIDTH fall out as zero via 32-bit zero extension.
    always_comb begin
        rd_byte = 8'h00;
        rld_w   = '0;
        if (ch_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 3'(c)) begin
                    rld_w = 32'(reload_q[c]);
                    case (rg)
                        4'h0, 4'h1, 4'h2, 4'h3: rd_byte = rld_w[{rg[1:0], 3'b000} +: 8];
                        4'h4:                   rd_byte = count_q[c][7:0];
                        4'h5, 4'h6, 4'h7:       rd_byte = snap_w[{rg[1:0], 3'b000} +: 8];
                        4'h8:                   rd_byte = {5'b0, ien_q[c], per_q[c], en_q[c]};
                        4'h9:                   rd_byte = {7'b0, exp_q[c]};
                        default:                rd_byte = 8'h00;
                    endcase
                end
            end
        end else if (off == OFF_IRQ) begin
            rd_byte = 8'(exp_q & ien_q);
        end else if (off == OFF_PRESC) begin
            rd_byte = presc_q;
        end
    end

    assign o_busNOE = !(hit && !i_ioNOE);
    assign o_bus    = o_busNOE ? 8'h00 : rd_byte;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_expansion_timer.sv
// Directed bench for expansion_timer (NUM_CH=4, WIDTH=16, BASE_ADDR=0x40).
// Cycle expectations below are counted in clock edges after a write commit.
module tb_expansion_timer;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] bus_w, bus_r, addr;
    logic       busnoe, sel, noe, nwe, irq;
    int         n_cmp = 0;
    int         n_err = 0;
    int         k;
    logic [7:0] d;
    logic       oe;

    expansion_timer #(.NUM_CH(4), .WIDTH(16), .BASE_ADDR(8'h40)) dut (
        .i_clk(clk), .i_resetn(resetn), .i_bus(bus_w), .o_bus(bus_r),
        .o_busNOE(busnoe), .i_ioSelect(sel), .i_ioAddress(addr),
        .i_ioNOE(noe), .i_ioNWE(nwe), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle write strobe: driven on a falling edge, commits on the next rising edge.
    task automatic wr(input logic [7:0] a, input logic [7:0] v, input logic s = 1'b1);
        @(negedge clk);
        sel = s; addr = a; bus_w = v; nwe = 1'b0;
        @(negedge clk);
        nwe = 1'b1; sel = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v, output logic oe_n);
        @(negedge clk);
        sel = 1'b1; addr = a; noe = 1'b0;
        #1 v = bus_r; oe_n = busnoe;
        @(negedge clk);
        noe = 1'b1; sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; sel = 1'b0; noe = 1'b1; nwe = 1'b1; addr = 8'h00; bus_w = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_busnoe", busnoe, 1);
        resetn = 1'b1;

        // every byte of the window reads zero after reset
        for (int o = 0; o < 66; o++) begin
            rd(8'(8'h40 + o), d, oe);
            chk($sformatf("rst_byte_%0h", o), d, 0);
        end
        chk("rd_oe_active", oe, 0);

        // ch0 periodic, RELOAD=3, PRESC=0: EXP at commit+4, irq at commit+5
        wr(8'h40, 8'h03);
        wr(8'h48, 8'h07);
        sel = 1'b1; addr = 8'h49; noe = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); #1;
            chk($sformatf("per_exp_k%0d", i), bus_r[0], (i >= 4) ? 1 : 0);
            chk($sformatf("per_irq_k%0d", i), irq, (i >= 5) ? 1 : 0);
        end
        noe = 1'b1; sel = 1'b0;
        // W1C lands on edge +8, which is also an expiry: set wins
        wr(8'h49, 8'h01);
        sel = 1'b1; addr = 8'h49; noe = 1'b0; #1;
        chk("w1c_coincident", bus_r[0], 1);
        noe = 1'b1; sel = 1'b0;
        // W1C on edge +10 clears; next expiry at +12, irq follows at +13
        wr(8'h49, 8'h01);
        sel = 1'b1; addr = 8'h49; noe = 1'b0; #1;
        chk("w1c_k10_exp", bus_r[0], 0);
        chk("w1c_k10_irq", irq, 1);
        for (int i = 11; i <= 13; i++) begin
            @(negedge clk); #1;
            chk($sformatf("w1c_exp_k%0d", i), bus_r[0], (i >= 12) ? 1 : 0);
            chk($sformatf("w1c_irq_k%0d", i), irq, (i >= 13) ? 1 : 0);
        end
        noe = 1'b1; sel = 1'b0;
        // held W1C strobe from edge +15 through +25: clears once; expiry at +24 must survive +25
        @(negedge clk);
        sel = 1'b1; addr = 8'h49; bus_w = 8'h01; nwe = 1'b0; noe = 1'b0;
        @(negedge clk); #1;
        chk("held_first_clear", bus_r[0], 0);
        repeat (10) @(negedge clk);
        #1;
        chk("held_single_commit", bus_r[0], 1);
        nwe = 1'b1; noe = 1'b1; sel = 1'b0;
        wr(8'h48, 8'h00);
        wr(8'h49, 8'h01);
        repeat (3) @(negedge clk);
        #1;
        chk("ch0_off_irq", irq, 0);

        // atomic COUNT read on ch2 crossing 0x0100 -> 0x00FF
        wr(8'h60, 8'h01);
        wr(8'h61, 8'h01);
        wr(8'h68, 8'h03);
        rd(8'h64, d, oe);
        chk("atom_b0_a", d, 8'h00);
        rd(8'h65, d, oe);
        chk("atom_b1_a", d, 8'h01);
        rd(8'h64, d, oe);
        chk("atom_b0_b", d, 8'hFC);
        rd(8'h65, d, oe);
        chk("atom_b1_b", d, 8'h00);
        wr(8'h68, 8'h00);
        rd(8'h64, d, oe);
        chk("freeze_a", d, 8'hF7);
        repeat (5) @(negedge clk);
        rd(8'h64, d, oe);
        chk("freeze_b", d, 8'hF7);

        // ch1 one-shot, RELOAD=2, PRESC=4 written two edges before enable:
        // ticks land on enable+3, +8, +13 -> EXP at +13
        wr(8'h50, 8'h02);
        wr(8'h81, 8'h04);
        wr(8'h58, 8'h01);
        sel = 1'b1; addr = 8'h59; noe = 1'b0;
        k = 0;
        while (k < 40 && bus_r[0] !== 1'b1) begin
            @(negedge clk); #1;
            k++;
        end
        noe = 1'b1; sel = 1'b0;
        chk("oneshot_latency", k, 13);
        rd(8'h58, d, oe);
        chk("oneshot_en_clr", d, 8'h00);
        rd(8'h54, d, oe);
        chk("oneshot_cnt_lo", d, 8'h00);
        repeat (20) @(negedge clk);
        rd(8'h54, d, oe);
        chk("oneshot_cnt_stay", d, 8'h00);

        // outside the window or unselected: ignored, bus stays disabled
        rd(8'h3F, d, oe);
        chk("below_oe", oe, 1);
        chk("below_data", d, 0);
        rd(8'h82, d, oe);
        chk("above_oe", oe, 1);
        wr(8'h3F, 8'hAA);
        wr(8'h82, 8'hAA);
        wr(8'h40, 8'h55, 1'b0);
        rd(8'h40, d, oe);
        chk("nosel_reload", d, 8'h03);
        rd(8'h81, d, oe);
        chk("presc_kept", d, 8'h04);

        // async reset while ch2 is running with its interrupt raised
        wr(8'h81, 8'h00);
        wr(8'h60, 8'h00);
        wr(8'h61, 8'h00);
        wr(8'h68, 8'h07);
        repeat (3) @(negedge clk);
        sel = 1'b1; addr = 8'h69; noe = 1'b0; #1;
        chk("pre_rst_irq", irq, 1);
        chk("pre_rst_exp", bus_r[0], 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_irq", irq, 0);
        chk("async_rst_exp", bus_r, 0);
        noe = 1'b1; sel = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("post_rst_irq", irq, 0);
        rd(8'h68, d, oe);
        chk("post_rst_ctrl", d, 0);
        rd(8'h69, d, oe);
        chk("post_rst_stat", d, 0);
        rd(8'h64, d, oe);
        chk("post_rst_cnt", d, 0);
        rd(8'h81, d, oe);
        chk("post_rst_presc", d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/expansion_timer.md
Name: expansion_timer

Overview:
- Parametrised multi-channel down-counter card on the 8-bit CPU expansion bus. It uses the same select/address/strobe protocol as the existing expansion UART card.
- Provides NUM_CH independent WIDTH-bit timers with one-shot/periodic modes, a shared programmable prescaler, per-channel expiry flags and a combined interrupt line.
- Sits beside other expansion cards in the design clock domain. Its bus output is merged by the board top.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- WIDTH, 16, counter width in bits (8, 16, 24 or 32).
- BASE_ADDR, 8'h40, first I/O address of the card window; BASE_ADDR + NUM_CH*16 + 1 must be <= 8'hFF.

Ports:
- i_clk  in  1  design clock; all state updates on its rising edge.
- i_resetn  in  1  asynchronous active-low reset.
- i_bus  in  8  write data from the CPU.
- o_bus  out  8  read data to the CPU.
- o_busNOE  out  1  active-low output enable for o_bus.
- i_ioSelect  in  1  high for an I/O cycle.
- i_ioAddress  in  8  I/O address.
- i_ioNOE  in  1  active-low read strobe.
- i_ioNWE  in  1  active-low write strobe.
- o_irq  out  1  high while any enabled-interrupt channel has its expiry flag set.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (i_clk, i_resetn).
- Reset: all registers 0, prescaler counter 0, snapshot 0, o_irq 0, o_busNOE 1, o_bus 0.
- hit = i_ioSelect & (BASE_ADDR <= i_ioAddress < BASE_ADDR + NUM_CH*16 + 2). off = i_ioAddress - BASE_ADDR. Channel c = off[6:4], reg = off[3:0].
- Per-channel register map (little-endian), bytes at or above WIDTH/8 read 0 and ignore writes:
  - 0x0-0x3 RELOAD, read/write.
  - 0x4-0x7 COUNT, read-only.
  - 0x8 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQEN; bits 7:3 read 0.
  - 0x9 STAT: bit0 EXP, write-1-to-clear.
  - 0xA-0xF read 0.
- Global registers:
  - off NUM_CH*16: IRQSTAT, read-only, bit c = EXP[c] & IRQEN[c].
  - off NUM_CH*16+1: PRESC, read/write 8-bit.
- Read path:
  - o_busNOE = ~(hit & ~i_ioNOE), combinational.
  - o_bus = addressed byte when o_busNOE = 0, else 0.
- Atomic count read:
  - Rising edge of read strobe (i_ioNOE 1→0 with hit) at COUNT byte 0 latches the full COUNT into a shared snapshot. That byte returns the live count.
  - COUNT bytes 1..3 return snapshot bytes.
- Write path:
  - i_ioNWE is registered. A write commits exactly once, in the cycle where hit & i_ioNWE=0 and the previous-cycle i_ioNWE was 1.
  - Data is taken from i_bus in that cycle. A held strobe does not re-write.
- Prescaler:
  - tick asserts for one cycle every PRESC+1 cycles. PRESC=0 gives tick every cycle.
  - A write to PRESC resets the prescaler counter to 0.
- EN 0→1 write: COUNT <= RELOAD in that cycle. The tick is ignored for that channel in that cycle.
- On tick with EN=1:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: EXP <= 1, then:
    - PERIODIC=1: COUNT <= RELOAD.
    - PERIODIC=0: EN <= 0; COUNT stays 0.
- Interval: RELOAD=N, PERIODIC gives expiry every (N+1) ticks. RELOAD=0 gives expiry every tick.
- RELOAD writes while running take effect at the next reload only. Multi-byte RELOAD writes are not atomic; software writes with EN=0.
- EN 1→0 write freezes COUNT.
- Simultaneous W1C and new expiry on the same channel: set wins, EXP stays 1.
- A CTRL write in the same cycle as an expiry: the written EN value wins over the one-shot auto-clear.
- o_irq = |IRQSTAT, registered one cycle after the EXP/IRQEN change.
- Accesses outside the window or with i_ioSelect=0 are ignored; o_busNOE stays 1.
- Reset asserted mid-operation clears all state immediately. Counting resumes only after software re-enables.

Test Plan:
- Reset then read all bytes of every channel -> all 0x00; o_busNOE=1 when idle; o_irq=0.
- PRESC=0, ch0 RELOAD=0x0003, CTRL=0x07 -> EXP set 4 cycles after the enable commit and every 4 cycles thereafter; o_irq high 1 cycle after the first EXP; W1C 0x01 to STAT clears it until the next expiry.
- ch1 one-shot: RELOAD=0x0002, PRESC=4, CTRL=0x01 -> EXP after 15 cycles; EN reads 0; COUNT reads 0x0000 and stays 0.
- Atomic read, WIDTH=16: running counter crosses 0x0100→0x00FF between the byte-0 and byte-1 reads -> byte pair is consistent (0x00/0x01 or 0xFF/0x00), never 0xFF/0x01.
- Write strobe held low 10 cycles on STAT, or a W1C coincident with an expiry tick -> single commit; EXP remains 1.
- Access to BASE_ADDR-1 and to BASE_ADDR+NUM_CH*16+2, plus a write with i_ioSelect=0 -> no register changes; o_busNOE stays 1.
- i_resetn pulsed low while ch2 is mid-count -> all outputs return to reset values asynchronously; no tick or expiry until re-enabled.
